// File: rtl/ring_stop.sv
// ring_stop: per-tile controller joining one tile to the LOTR request and
// response rings.
//   QClk, RstQnnnH        clock, synchronous active-high reset
//   CoreID                this tile's 8-bit ID
//   RingReqIn*/RingRspIn*   ring inputs (Q500)
//   RingReqOut*/RingRspOut* ring outputs (Q502, registered)
//   C2RReq*/C2RRsp*       local request/response to inject, Ready = FIFO not full
//   R2CReq*               inbound request FIFO head toward local memory
//   R2CRsp*               response delivered to core, 1-cycle pulse at Q502
// Traffic crosses the tile in exactly two cycles: Q501 registers the ring
// inputs, and Q502 registers the consume/forward/inject decision.

package ring_stop_pkg;
    typedef logic [3:0] t_opcode;

    typedef struct packed {
        logic [9:0]  requestor;
        t_opcode     opcode;
        logic [31:0] address;
        logic [31:0] data;
    } t_msg;
endpackage

// ring_stop_fifo: small circular FIFO. The caller guards push with !o_full
// and pop with !o_empty.
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_push, i_data      write strobe and payload
//   i_pop               read strobe (head advances)
//   o_head              current head entry
//   o_empty, o_full     occupancy flags
module ring_stop_fifo
    import ring_stop_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_push,
    input  t_msg i_data,
    input  logic i_pop,
    output t_msg o_head,
    output logic o_empty,
    output logic o_full
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    t_msg          r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;

    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    // Pointers are AW bits wide, so they wrap at DEPTH on their own.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (i_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rptr];
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == FULL_CNT);
endmodule

module ring_stop
    import ring_stop_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 2,
    parameter int unsigned ADDR_ID_MSB = 31
) (
    input  logic        QClk,
    input  logic        RstQnnnH,
    input  logic [7:0]  CoreID,

    input  logic        RingReqInValidQ500H,
    input  logic [9:0]  RingReqInRequestorQ500H,
    input  t_opcode     RingReqInOpcodeQ500H,
    input  logic [31:0] RingReqInAddressQ500H,
    input  logic [31:0] RingReqInDataQ500H,

    input  logic        RingRspInValidQ500H,
    input  logic [9:0]  RingRspInRequestorQ500H,
    input  t_opcode     RingRspInOpcodeQ500H,
    input  logic [31:0] RingRspInAddressQ500H,
    input  logic [31:0] RingRspInDataQ500H,

    output logic        RingReqOutValidQ502H,
    output logic [9:0]  RingReqOutRequestorQ502H,
    output t_opcode     RingReqOutOpcodeQ502H,
    output logic [31:0] RingReqOutAddressQ502H,
    output logic [31:0] RingReqOutDataQ502H,

    output logic        RingRspOutValidQ502H,
    output logic [9:0]  RingRspOutRequestorQ502H,
    output t_opcode     RingRspOutOpcodeQ502H,
    output logic [31:0] RingRspOutAddressQ502H,
    output logic [31:0] RingRspOutDataQ502H,

    input  logic        C2RReqValid,
    input  logic [9:0]  C2RReqRequestor,
    input  t_opcode     C2RReqOpcode,
    input  logic [31:0] C2RReqAddress,
    input  logic [31:0] C2RReqData,
    output logic        C2RReqReady,

    input  logic        C2RRspValid,
    input  logic [9:0]  C2RRspRequestor,
    input  t_opcode     C2RRspOpcode,
    input  logic [31:0] C2RRspAddress,
    input  logic [31:0] C2RRspData,
    output logic        C2RRspReady,

    output logic        R2CReqValid,
    output logic [9:0]  R2CReqRequestor,
    output t_opcode     R2CReqOpcode,
    output logic [31:0] R2CReqAddress,
    output logic [31:0] R2CReqData,
    input  logic        R2CReqReady,

    output logic        R2CRspValid,
    output logic [9:0]  R2CRspRequestor,
    output t_opcode     R2CRspOpcode,
    output logic [31:0] R2CRspAddress,
    output logic [31:0] R2CRspData
);
    t_msg w_req_in, w_rsp_in, w_c2r_req, w_c2r_rsp;

    logic r_req_v_q501, r_rsp_v_q501;
    t_msg r_req_q501, r_rsp_q501;
    logic r_req_v_q502, r_rsp_v_q502, r_r2c_rsp_v;
    t_msg r_req_q502, r_rsp_q502, r_r2c_rsp;

    t_msg w_oreq_head, w_orsp_head, w_ireq_head;
    logic w_oreq_empty, w_oreq_full, w_orsp_empty, w_orsp_full;
    logic w_ireq_empty, w_ireq_full;
    logic w_oreq_push, w_orsp_push, w_ireq_pop;

    logic w_req_hit, w_in_push, w_req_fwd, w_oreq_pop, w_req_nxt_v;
    logic w_rsp_hit, w_rsp_fwd, w_orsp_pop, w_rsp_nxt_v;
    t_msg w_req_nxt, w_rsp_nxt;

    assign w_req_in  = {RingReqInRequestorQ500H, RingReqInOpcodeQ500H,
                        RingReqInAddressQ500H, RingReqInDataQ500H};
    assign w_rsp_in  = {RingRspInRequestorQ500H, RingRspInOpcodeQ500H,
                        RingRspInAddressQ500H, RingRspInDataQ500H};
    assign w_c2r_req = {C2RReqRequestor, C2RReqOpcode, C2RReqAddress, C2RReqData};
    assign w_c2r_rsp = {C2RRspRequestor, C2RRspOpcode, C2RRspAddress, C2RRspData};

    assign w_oreq_push = C2RReqValid && !w_oreq_full;
    assign w_orsp_push = C2RRspValid && !w_orsp_full;
    assign w_ireq_pop  = !w_ireq_empty && R2CReqReady;

    ring_stop_fifo #(.DEPTH(FIFO_DEPTH)) u_oreq_fifo (
        .i_clk(QClk), .i_rst(RstQnnnH), .i_push(w_oreq_push), .i_data(w_c2r_req),
        .i_pop(w_oreq_pop), .o_head(w_oreq_head), .o_empty(w_oreq_empty),
        .o_full(w_oreq_full)
    );

    ring_stop_fifo #(.DEPTH(FIFO_DEPTH)) u_orsp_fifo (
        .i_clk(QClk), .i_rst(RstQnnnH), .i_push(w_orsp_push), .i_data(w_c2r_rsp),
        .i_pop(w_orsp_pop), .o_head(w_orsp_head), .o_empty(w_orsp_empty),
        .o_full(w_orsp_full)
    );

    ring_stop_fifo #(.DEPTH(FIFO_DEPTH)) u_ireq_fifo (
        .i_clk(QClk), .i_rst(RstQnnnH), .i_push(w_in_push), .i_data(r_req_q501),
        .i_pop(w_ireq_pop), .o_head(w_ireq_head), .o_empty(w_ireq_empty),
        .o_full(w_ireq_full)
    );

    // Slot decision at Q501. A request for this tile that cannot be buffered
    // is forwarded so it recirculates. Injection only fills a slot that is
    // empty or was just consumed, so forwarded traffic always wins.
    always_comb begin
        w_req_hit   = r_req_v_q501 &&
                      (r_req_q501.address[ADDR_ID_MSB -: 8] == CoreID);
        w_in_push   = w_req_hit && !w_ireq_full;
        w_req_fwd   = r_req_v_q501 && !w_in_push;
        w_oreq_pop  = !w_req_fwd && !w_oreq_empty;
        w_req_nxt_v = w_req_fwd || w_oreq_pop;
        w_req_nxt   = '0;
        if (w_req_fwd) begin
            w_req_nxt = r_req_q501;
        end else if (w_oreq_pop) begin
            w_req_nxt = w_oreq_head;
        end

        w_rsp_hit   = r_rsp_v_q501 && (r_rsp_q501.requestor[9:2] == CoreID);
        w_rsp_fwd   = r_rsp_v_q501 && !w_rsp_hit;
        w_orsp_pop  = !w_rsp_fwd && !w_orsp_empty;
        w_rsp_nxt_v = w_rsp_fwd || w_orsp_pop;
        w_rsp_nxt   = '0;
        if (w_rsp_fwd) begin
            w_rsp_nxt = r_rsp_q501;
        end else if (w_orsp_pop) begin
            w_rsp_nxt = w_orsp_head;
        end
    end

    always_ff @(posedge QClk) begin
        if (RstQnnnH) begin
            r_req_v_q501 <= 1'b0;
            r_req_q501   <= '0;
            r_rsp_v_q501 <= 1'b0;
            r_rsp_q501   <= '0;
            r_req_v_q502 <= 1'b0;
            r_req_q502   <= '0;
            r_rsp_v_q502 <= 1'b0;
            r_rsp_q502   <= '0;
            r_r2c_rsp_v  <= 1'b0;
            r_r2c_rsp    <= '0;
        end else begin
            r_req_v_q501 <= RingReqInValidQ500H;
            r_req_q501   <= w_req_in;
            r_rsp_v_q501 <= RingRspInValidQ500H;
            r_rsp_q501   <= w_rsp_in;
            r_req_v_q502 <= w_req_nxt_v;
            r_req_q502   <= w_req_nxt;
            r_rsp_v_q502 <= w_rsp_nxt_v;
            r_rsp_q502   <= w_rsp_nxt;
            r_r2c_rsp_v  <= w_rsp_hit;
            r_r2c_rsp    <= w_rsp_hit ? r_rsp_q501 : '0;
        end
    end

    assign RingReqOutValidQ502H     = r_req_v_q502;
    assign RingReqOutRequestorQ502H = r_req_q502.requestor;
    assign RingReqOutOpcodeQ502H    = r_req_q502.opcode;
    assign RingReqOutAddressQ502H   = r_req_q502.address;
    assign RingReqOutDataQ502H      = r_req_q502.data;

    assign RingRspOutValidQ502H     = r_rsp_v_q502;
    assign RingRspOutRequestorQ502H = r_rsp_q502.requestor;
    assign RingRspOutOpcodeQ502H    = r_rsp_q502.opcode;
    assign RingRspOutAddressQ502H   = r_rsp_q502.address;
    assign RingRspOutDataQ502H      = r_rsp_q502.data;

    assign C2RReqReady = !w_oreq_full;
    assign C2RRspReady = !w_orsp_full;

    // FIFO storage is not reset, so the head is masked while empty.
    assign R2CReqValid     = !w_ireq_empty;
    assign R2CReqRequestor = w_ireq_empty ? '0 : w_ireq_head.requestor;
    assign R2CReqOpcode    = w_ireq_empty ? '0 : w_ireq_head.opcode;
    assign R2CReqAddress   = w_ireq_empty ? '0 : w_ireq_head.address;
    assign R2CReqData      = w_ireq_empty ? '0 : w_ireq_head.data;

    assign R2CRspValid     = r_r2c_rsp_v;
    assign R2CRspRequestor = r_r2c_rsp.requestor;
    assign R2CRspOpcode    = r_r2c_rsp.opcode;
    assign R2CRspAddress   = r_r2c_rsp.address;
    assign R2CRspData      = r_r2c_rsp.data;
endmodule

// File: tb/tb_ring_stop.sv
// Directed bench for ring_stop: reset state, pass-through, consume plus
// inject, blocked injection, inbound-full recirculation, response delivery
// and reset in the middle of traffic.
module tb_ring_stop;
    import ring_stop_pkg::*;

    logic       QClk = 1'b0;
    logic       RstQnnnH;
    logic [7:0] CoreID;
    logic       r2c_rdy;

    logic ri_v, si_v, cq_v, cs_v;
    t_msg ri, si, cq, cs;

    logic        ro_v, so_v, iq_v, ir_v, c2r_req_rdy, c2r_rsp_rdy;
    logic [9:0]  ro_rqr, so_rqr, iq_rqr, ir_rqr;
    t_opcode     ro_op, so_op, iq_op, ir_op;
    logic [31:0] ro_addr, so_addr, iq_addr, ir_addr;
    logic [31:0] ro_data, so_data, iq_data, ir_data;

    int n_cmp = 0;
    int n_err = 0;

    always #5 QClk = ~QClk;

    ring_stop #(.FIFO_DEPTH(2), .ADDR_ID_MSB(31)) dut (
        .QClk(QClk), .RstQnnnH(RstQnnnH), .CoreID(CoreID),
        .RingReqInValidQ500H(ri_v), .RingReqInRequestorQ500H(ri.requestor),
        .RingReqInOpcodeQ500H(ri.opcode), .RingReqInAddressQ500H(ri.address),
        .RingReqInDataQ500H(ri.data),
        .RingRspInValidQ500H(si_v), .RingRspInRequestorQ500H(si.requestor),
        .RingRspInOpcodeQ500H(si.opcode), .RingRspInAddressQ500H(si.address),
        .RingRspInDataQ500H(si.data),
        .RingReqOutValidQ502H(ro_v), .RingReqOutRequestorQ502H(ro_rqr),
        .RingReqOutOpcodeQ502H(ro_op), .RingReqOutAddressQ502H(ro_addr),
        .RingReqOutDataQ502H(ro_data),
        .RingRspOutValidQ502H(so_v), .RingRspOutRequestorQ502H(so_rqr),
        .RingRspOutOpcodeQ502H(so_op), .RingRspOutAddressQ502H(so_addr),
        .RingRspOutDataQ502H(so_data),
        .C2RReqValid(cq_v), .C2RReqRequestor(cq.requestor), .C2RReqOpcode(cq.opcode),
        .C2RReqAddress(cq.address), .C2RReqData(cq.data), .C2RReqReady(c2r_req_rdy),
        .C2RRspValid(cs_v), .C2RRspRequestor(cs.requestor), .C2RRspOpcode(cs.opcode),
        .C2RRspAddress(cs.address), .C2RRspData(cs.data), .C2RRspReady(c2r_rsp_rdy),
        .R2CReqValid(iq_v), .R2CReqRequestor(iq_rqr), .R2CReqOpcode(iq_op),
        .R2CReqAddress(iq_addr), .R2CReqData(iq_data), .R2CReqReady(r2c_rdy),
        .R2CRspValid(ir_v), .R2CRspRequestor(ir_rqr), .R2CRspOpcode(ir_op),
        .R2CRspAddress(ir_addr), .R2CRspData(ir_data)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic t_msg mk(input logic [9:0] r, input t_opcode o,
                                input logic [31:0] a, input logic [31:0] d);
        t_msg m;
        m.requestor = r;
        m.opcode    = o;
        m.address   = a;
        m.data      = d;
        return m;
    endfunction

    task automatic tick();
        @(posedge QClk);
        #1;
    endtask

    task automatic idle();
        ri_v = 1'b0; si_v = 1'b0; cq_v = 1'b0; cs_v = 1'b0;
        ri = '0; si = '0; cq = '0; cs = '0;
    endtask

    initial begin
        idle();
        CoreID   = 8'd1;
        r2c_rdy  = 1'b0;
        RstQnnnH = 1'b1;
        tick();
        tick();
        RstQnnnH = 1'b0;

        // reset state
        chk("rst_req_out_v", ro_v, 0);
        chk("rst_rsp_out_v", so_v, 0);
        chk("rst_r2c_req_v", iq_v, 0);
        chk("rst_r2c_rsp_v", ir_v, 0);
        chk("rst_req_rdy", c2r_req_rdy, 1);
        chk("rst_rsp_rdy", c2r_rsp_rdy, 1);
        chk("rst_req_out_data", ro_data, 0);

        // pass-through of a foreign request, 2-cycle latency
        ri_v = 1'b1;
        ri   = mk(10'h0A5, 4'h3, 32'h0200_0010, 32'hDEAD_BEEF);
        tick();
        idle();
        chk("pt_early_v", ro_v, 0);
        tick();
        chk("pt_v", ro_v, 1);
        chk("pt_addr", ro_addr, 32'h0200_0010);
        chk("pt_data", ro_data, 32'hDEAD_BEEF);
        chk("pt_rqr", ro_rqr, 10'h0A5);
        chk("pt_op", ro_op, 4'h3);
        chk("pt_r2c_v", iq_v, 0);
        tick();
        chk("pt_after_v", ro_v, 0);

        // consume and inject in the same slot
        ri_v = 1'b1;
        ri   = mk(10'h011, 4'h1, 32'h0100_0004, 32'hCAFE_0001);
        cq_v = 1'b1;
        cq   = mk(10'h004, 4'h2, 32'h0300_0000, 32'h1111_2222);
        tick();
        idle();
        tick();
        chk("ci_r2c_v", iq_v, 1);
        chk("ci_r2c_addr", iq_addr, 32'h0100_0004);
        chk("ci_r2c_data", iq_data, 32'hCAFE_0001);
        chk("ci_out_v", ro_v, 1);
        chk("ci_out_addr", ro_addr, 32'h0300_0000);
        chk("ci_out_data", ro_data, 32'h1111_2222);
        r2c_rdy = 1'b1;
        tick();
        r2c_rdy = 1'b0;
        chk("ci_drained", iq_v, 0);
        chk("ci_out_idle", ro_v, 0);

        // injection blocked by three foreign requests
        ri_v = 1'b1;
        ri   = mk(10'h000, 4'h1, 32'h0500_0000, 32'h0000_00F1);
        cq_v = 1'b1;
        cq   = mk(10'h004, 4'h1, 32'h0600_0000, 32'h0000_00A1);
        tick();
        chk("blk_rdy_one", c2r_req_rdy, 1);
        ri.data = 32'h0000_00F2;
        cq.data = 32'h0000_00A2;
        tick();
        cq_v = 1'b0;
        chk("blk_rdy_full", c2r_req_rdy, 0);
        chk("blk_f1_v", ro_v, 1);
        chk("blk_f1_data", ro_data, 32'h0000_00F1);
        ri.data = 32'h0000_00F3;
        tick();
        ri_v = 1'b0;
        chk("blk_f2_data", ro_data, 32'h0000_00F2);
        tick();
        chk("blk_f3_data", ro_data, 32'h0000_00F3);
        tick();
        chk("blk_l1_v", ro_v, 1);
        chk("blk_l1_addr", ro_addr, 32'h0600_0000);
        chk("blk_l1_data", ro_data, 32'h0000_00A1);
        chk("blk_rdy_back", c2r_req_rdy, 1);
        tick();
        chk("blk_l2_data", ro_data, 32'h0000_00A2);
        tick();
        chk("blk_idle_v", ro_v, 0);

        // inbound FIFO full: third request recirculates
        idle();
        ri_v = 1'b1;
        ri   = mk(10'h020, 4'h1, 32'h0100_0100, 32'h0000_00B1);
        tick();
        ri.address = 32'h0100_0104;
        ri.data    = 32'h0000_00B2;
        tick();
        chk("bn_b1_out_v", ro_v, 0);
        chk("bn_head_b1", iq_data, 32'h0000_00B1);
        chk("bn_head_addr", iq_addr, 32'h0100_0100);
        ri.address = 32'h0100_0108;
        ri.data    = 32'h0000_00B3;
        tick();
        ri_v = 1'b0;
        chk("bn_b2_out_v", ro_v, 0);
        tick();
        chk("bn_fwd_v", ro_v, 1);
        chk("bn_fwd_addr", ro_addr, 32'h0100_0108);
        chk("bn_fwd_data", ro_data, 32'h0000_00B3);
        chk("bn_head_hold", iq_data, 32'h0000_00B1);
        r2c_rdy = 1'b1;
        tick();
        chk("bn_drain_v", iq_v, 1);
        chk("bn_drain_b2", iq_data, 32'h0000_00B2);
        tick();
        chk("bn_empty", iq_v, 0);
        r2c_rdy = 1'b0;

        // response delivery
        idle();
        si_v = 1'b1;
        si   = mk({8'd1, 2'd3}, 4'h5, 32'h0000_0040, 32'h1234_5678);
        tick();
        idle();
        tick();
        chk("rd_v", ir_v, 1);
        chk("rd_data", ir_data, 32'h1234_5678);
        chk("rd_rqr", ir_rqr, 10'h007);
        chk("rd_op", ir_op, 4'h5);
        chk("rd_ring_v", so_v, 0);
        tick();
        chk("rd_pulse_end", ir_v, 0);

        // response consumed and local response injected into same slot
        si_v = 1'b1;
        si   = mk({8'd1, 2'd0}, 4'h5, 32'h0000_0044, 32'hAAAA_0001);
        cs_v = 1'b1;
        cs   = mk({8'd9, 2'd1}, 4'h6, 32'h0000_0080, 32'h0000_0055);
        tick();
        idle();
        tick();
        chk("ri_v", ir_v, 1);
        chk("ri_data", ir_data, 32'hAAAA_0001);
        chk("ri_ring_v", so_v, 1);
        chk("ri_ring_data", so_data, 32'h0000_0055);
        chk("ri_ring_rqr", so_rqr, 10'h025);

        // foreign response forwarded
        si_v = 1'b1;
        si   = mk({8'd4, 2'd0}, 4'h7, 32'h0000_0048, 32'h0000_0077);
        tick();
        idle();
        tick();
        chk("rf_ring_v", so_v, 1);
        chk("rf_ring_data", so_data, 32'h0000_0077);
        chk("rf_rqr", so_rqr, 10'h010);
        chk("rf_r2c_v", ir_v, 0);

        // reset mid-operation
        ri_v = 1'b1;
        ri   = mk(10'h000, 4'h1, 32'h0100_0200, 32'h0000_00C1);
        tick();
        ri = mk(10'h000, 4'h1, 32'h0700_0000, 32'h0000_00C2);
        cq_v = 1'b1;
        cq   = mk(10'h004, 4'h2, 32'h0800_0000, 32'h0000_00D1);
        tick();
        ri.data = 32'h0000_00C3;
        cq.data = 32'h0000_00D2;
        tick();
        chk("mr_pre_r2c_v", iq_v, 1);
        chk("mr_pre_ring_v", ro_v, 1);
        chk("mr_pre_rdy", c2r_req_rdy, 0);
        cq_v     = 1'b0;
        RstQnnnH = 1'b1;
        tick();
        RstQnnnH = 1'b0;
        chk("mr_ring_v", ro_v, 0);
        chk("mr_rsp_v", so_v, 0);
        chk("mr_r2c_v", iq_v, 0);
        chk("mr_r2c_rsp_v", ir_v, 0);
        chk("mr_req_rdy", c2r_req_rdy, 1);
        chk("mr_rsp_rdy", c2r_rsp_rdy, 1);
        ri = mk(10'h033, 4'h4, 32'h0900_0000, 32'h0000_00E1);
        tick();
        ri_v = 1'b0;
        chk("mr_q501_clear", ro_v, 0);
        tick();
        chk("mr_resume_v", ro_v, 1);
        chk("mr_resume_data", ro_data, 32'h0000_00E1);
        chk("mr_resume_rqr", ro_rqr, 10'h033);
        tick();
        chk("mr_no_leftover", ro_v, 0);
        chk("mr_no_leftover_r2c", iq_v, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ring_stop.md
Name: ring_stop

Overview:
- Per-tile ring controller that attaches one tile to the LOTR request ring and the LOTR response ring.
- Each cycle it consumes ring traffic addressed to this tile and forwards all other traffic.
- It injects locally generated requests and responses into free ring slots.
- Ring outputs are registered, so ring traversal through each tile is Q500 in to Q502 out, a fixed 2-cycle latency.

Parameters:
- FIFO_DEPTH, 2: depth of each of the three local FIFOs (outbound req, outbound rsp, inbound req); power of 2, minimum 2.
- ADDR_ID_MSB, 31: MSB of the 8-bit target-CoreID field in Address; the field is Address[ADDR_ID_MSB:ADDR_ID_MSB-7].

Ports:
- QClk  in  1  clock
- RstQnnnH  in  1  synchronous active-high reset
- CoreID  in  8  this tile's ID; static after reset
- RingReqIn{Valid,Requestor,Opcode,Address,Data}Q500H  in  1/10/t_opcode/32/32  request ring input
- RingRspIn{Valid,Requestor,Opcode,Address,Data}Q500H  in  1/10/t_opcode/32/32  response ring input
- RingReqOut{Valid,Requestor,Opcode,Address,Data}Q502H  out  1/10/t_opcode/32/32  request ring output, registered
- RingRspOut{Valid,Requestor,Opcode,Address,Data}Q502H  out  1/10/t_opcode/32/32  response ring output, registered
- C2RReq{Valid,Requestor,Opcode,Address,Data}  in  1/10/t_opcode/32/32  core request to ring
- C2RReqReady  out  1  outbound request FIFO not full
- C2RRsp{Valid,Requestor,Opcode,Address,Data}  in  1/10/t_opcode/32/32  local memory response to ring
- C2RRspReady  out  1  outbound response FIFO not full
- R2CReq{Valid,Requestor,Opcode,Address,Data}  out  1/10/t_opcode/32/32  inbound request to local memory
- R2CReqReady  in  1  local memory accepts inbound request
- R2CRsp{Valid,Requestor,Opcode,Address,Data}  out  1/10/t_opcode/32/32  response delivered to core; 1-cycle pulse, no backpressure

Behaviour:
- Reset (sync, RstQnnnH=1 at a QClk edge):
  - All Q501/Q502 valid flops clear to 0; data fields clear to 0.
  - All FIFOs empty; C2RReqReady=C2RRspReady=1; R2CReqValid=R2CRspValid=0.
  - Reset mid-operation drops all in-flight slots and FIFO contents with no partial output.
- Pipeline: stage Q501 registers the ring inputs; stage Q502 registers the arbitration result. Every field propagates with exactly 2 cycles of latency.
- Request ring, at Q501, evaluated in priority order:
  - (a) Valid and target ID == CoreID and inbound FIFO not full: push to inbound FIFO; slot becomes free.
  - (b) Valid and target ID == CoreID and inbound FIFO full: forward unchanged, so the request recirculates. No drop, no error.
  - (c) Valid and target ID != CoreID: forward unchanged.
  - (d) Slot free, including after (a): if the outbound request FIFO is non-empty, pop its head into the slot; otherwise drive Valid=0.
- A local request addressed to its own CoreID is still injected and travels the full ring; it is consumed on return via (a).
- Response ring, at Q501:
  - Valid and Requestor[9:2] == CoreID: drive R2CRsp* with Valid=1 for one cycle, aligned to Q502; slot becomes free.
  - Otherwise forward unchanged.
  - Free slot: pop the head of the outbound response FIFO if non-empty.
- Consume and inject on the same cycle in the same slot is legal and required; this is the back-to-back reuse case.
- Forwarded traffic always has priority over injection. Injection only happens into an empty or consumed slot.
- FIFOs:
  - Push when Valid&&Ready; pop as above.
  - Simultaneous push and pop when full is not allowed, because Ready is already 0.
  - Simultaneous push and pop when non-empty keeps the count unchanged.
  - Read and write pointers wrap at FIFO_DEPTH.
- R2CReq* presents the inbound FIFO head, with Valid = not empty. The entry is popped on R2CReqValid&&R2CReqReady.
- When Valid=0, opcode/data fields are don't-care on ring outputs, but are driven to 0.

Test Plan:
- Pass-through: CoreID=1; req in Valid=1, Address=0x0200_0010, Data=0xDEADBEEF at cycle N → RingReqOut identical at N+2; R2CReqValid stays 0.
- Consume plus inject in the same slot: CoreID=1; outbound FIFO holds a req to 0x0300_0000; ring req arrives to 0x0100_0004 at N → R2CReqValid=1 with Address 0x0100_0004 at N+2, and RingReqOut carries the 0x0300_0000 req at N+2.
- Injection blocked: outbound FIFO non-empty; foreign reqs arrive on 3 consecutive cycles then idle → the 3 foreign reqs pass through, and the local req appears on the 4th output cycle. C2RReqReady=0 after 2 further pushes.
- Inbound full bounce: R2CReqReady=0; 3 reqs targeting this tile arrive → the first 2 are buffered, the 3rd reappears on RingReqOut unchanged. After R2CReqReady=1, the FIFO drains in order.
- Response delivery: rsp with Requestor={8'd1,2'd3}, Data=0x12345678 at N to CoreID=1 → R2CRspValid pulse at N+2 with the same fields; RingRspOutValid=0 at N+2 unless the outbound rsp FIFO was non-empty.
- Reset mid-operation: FIFOs partially full and ring slots valid; assert RstQnnnH for 1 cycle → the next cycle shows all output valids 0 and both Ready=1. Traffic resumes correctly 1 cycle after deassertion.
